// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID instruction into ALU control, detects load-use
// hazards and inserts bubbles. Optional ID_EX_PERF_CNT_EN adds issue/bubble counters.
module id_ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic [3:0]            ex_alu_control,
  output logic [DATA_W-1:0]     ex_alu_a,
  output logic [DATA_W-1:0]     ex_alu_b,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_branch,
  output logic [DATA_W-1:0]     ex_branch_offset,
  output logic                  ex_illegal
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_bubbles
`endif
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;

  // Instruction fields
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs_a;
  logic [REG_ADDR_W-1:0] rt_a;
  logic [REG_ADDR_W-1:0] rd_a;
  logic [DATA_W-1:0]     imm_ext;

  assign opcode  = id_instr[31:26];
  assign funct   = id_instr[5:0];
  assign rs_a    = REG_ADDR_W'(id_instr[25:21]);
  assign rt_a    = REG_ADDR_W'(id_instr[20:16]);
  assign rd_a    = REG_ADDR_W'(id_instr[15:11]);
  assign imm_ext = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

  // Decoder outputs
  logic                  dec_ok;
  logic                  dec_illegal;
  logic [3:0]            dec_alu;
  logic                  dec_use_imm;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic                  dec_rw;
  logic                  dec_mr;
  logic                  dec_mw;
  logic                  dec_m2r;
  logic                  dec_br;
  logic                  reads_rt;

  // EX registers
  logic                  valid_q, valid_d;
  logic [3:0]            alu_control_q, alu_control_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic [DATA_W-1:0]     store_data_q, store_data_d;
  logic [REG_ADDR_W-1:0] dest_reg_q, dest_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  branch_q, branch_d;
  logic [DATA_W-1:0]     branch_offset_q, branch_offset_d;
  logic                  illegal_q, illegal_d;

  logic load_instr;
  logic load_bubble;
  logic bubble_evt;

  always_comb begin
    dec_ok      = 1'b0;
    dec_illegal = 1'b0;
    dec_alu     = 4'b0000;
    dec_use_imm = 1'b0;
    dec_dest    = '0;
    dec_rw      = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_m2r     = 1'b0;
    dec_br      = 1'b0;
    // All-zero word is a NOP: neither legal nor illegal
    if (id_instr != 32'h0) begin
      case (opcode)
        OpRtype: begin
          if (funct == FnAdd || funct == FnSub) begin
            dec_ok   = 1'b1;
            dec_alu  = (funct == FnSub) ? AluSub : AluAdd;
            dec_dest = rd_a;
            dec_rw   = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OpAddi: begin
          dec_ok      = 1'b1;
          dec_alu     = AluAdd;
          dec_use_imm = 1'b1;
          dec_dest    = rt_a;
          dec_rw      = 1'b1;
        end
        OpLw: begin
          dec_ok      = 1'b1;
          dec_alu     = AluAdd;
          dec_use_imm = 1'b1;
          dec_dest    = rt_a;
          dec_rw      = 1'b1;
          dec_mr      = 1'b1;
          dec_m2r     = 1'b1;
        end
        OpSw: begin
          dec_ok      = 1'b1;
          dec_alu     = AluAdd;
          dec_use_imm = 1'b1;
          dec_mw      = 1'b1;
        end
        OpBeq: begin
          dec_ok  = 1'b1;
          dec_alu = AluSub;
          dec_br  = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
    if (dec_dest == '0) begin
      dec_rw = 1'b0;
    end
  end

  assign reads_rt = (opcode == OpRtype) || (opcode == OpSw) || (opcode == OpBeq);

  assign hazard_stall = id_valid && valid_q && mem_read_q && (dest_reg_q != '0) &&
                        ((dest_reg_q == rs_a) || ((dest_reg_q == rt_a) && reads_rt));

  always_comb begin
    load_instr  = 1'b0;
    load_bubble = 1'b0;
    illegal_d   = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
    end else if (stall_in) begin
      load_bubble = 1'b0;
    end else if (hazard_stall) begin
      load_bubble = 1'b1;
    end else if (id_valid && dec_ok) begin
      load_instr = 1'b1;
    end else begin
      load_bubble = 1'b1;
      illegal_d   = id_valid && dec_illegal;
    end
  end

  always_comb begin
    valid_d         = valid_q;
    alu_control_d   = alu_control_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    store_data_d    = store_data_q;
    dest_reg_d      = dest_reg_q;
    reg_write_d     = reg_write_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    branch_d        = branch_q;
    branch_offset_d = branch_offset_q;
    if (load_instr) begin
      valid_d         = 1'b1;
      alu_control_d   = dec_alu;
      alu_a_d         = id_rs_data;
      alu_b_d         = dec_use_imm ? imm_ext : id_rt_data;
      store_data_d    = id_rt_data;
      dest_reg_d      = dec_dest;
      reg_write_d     = dec_rw;
      mem_read_d      = dec_mr;
      mem_write_d     = dec_mw;
      mem_to_reg_d    = dec_m2r;
      branch_d        = dec_br;
      branch_offset_d = imm_ext << 2;
    end else if (load_bubble) begin
      valid_d         = 1'b0;
      alu_control_d   = 4'b0000;
      alu_a_d         = '0;
      alu_b_d         = '0;
      store_data_d    = '0;
      dest_reg_d      = '0;
      reg_write_d     = 1'b0;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      mem_to_reg_d    = 1'b0;
      branch_d        = 1'b0;
      branch_offset_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= 1'b0;
      alu_control_q   <= 4'b0000;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      store_data_q    <= '0;
      dest_reg_q      <= '0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      branch_q        <= 1'b0;
      branch_offset_q <= '0;
      illegal_q       <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      alu_control_q   <= alu_control_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      store_data_q    <= store_data_d;
      dest_reg_q      <= dest_reg_d;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      branch_q        <= branch_d;
      branch_offset_q <= branch_offset_d;
      illegal_q       <= illegal_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_alu_control   = alu_control_q;
  assign ex_alu_a         = alu_a_q;
  assign ex_alu_b         = alu_b_q;
  assign ex_store_data    = store_data_q;
  assign ex_dest_reg      = dest_reg_q;
  assign ex_reg_write     = reg_write_q;
  assign ex_mem_read      = mem_read_q;
  assign ex_mem_write     = mem_write_q;
  assign ex_mem_to_reg    = mem_to_reg_q;
  assign ex_branch        = branch_q;
  assign ex_branch_offset = branch_offset_q;
  assign ex_illegal       = illegal_q;

  // Bubbles caused by hazard or flush; idle/NOP/illegal bubbles are not counted
  assign bubble_evt = flush || (!stall_in && hazard_stall);

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] bubbles_q, bubbles_d;

  always_comb begin
    issued_d  = issued_q + (load_instr ? 32'd1 : 32'd0);
    bubbles_d = bubbles_q + (bubble_evt ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q  <= '0;
      bubbles_q <= '0;
    end else begin
      issued_q  <= issued_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_issued  = issued_q;
  assign perf_bubbles = bubbles_q;
`else
  logic unused_bubble_evt;
  assign unused_bubble_evt = bubble_evt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are pushed on each drive and popped
// after the clock edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, id_valid, stall_in, flush;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_branch, ex_illegal;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_branch_offset;
  logic [4:0]  ex_dest_reg;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_issued, perf_bubbles;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall_in(stall_in), .flush(flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data),
    .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_branch_offset(ex_branch_offset), .ex_illegal(ex_illegal)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_bubbles(perf_bubbles)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [31:0] off;
    logic [4:0]  dest;
    logic        rw, mr, mw, m2r, br, ill;
  } ex_t;

  typedef struct {
    ex_t e;
    bit  chk_sd;
    bit  chk_off;
  } item_t;

  item_t       sb[$];
  item_t       cur;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] perf_iss_m = 0;
  logic [31:0] perf_bub_m = 0;

  localparam logic [31:0] I_ADD  = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] I_SUB  = 32'h00221822; // sub $3,$1,$2
  localparam logic [31:0] I_ADDI = 32'h2026FFFD; // addi $6,$1,-3
  localparam logic [31:0] I_LW   = 32'h8C24FFF8; // lw $4,-8($1)
  localparam logic [31:0] I_SW   = 32'hAC220010; // sw $2,16($1)
  localparam logic [31:0] I_BEQ  = 32'h10220003; // beq $1,$2,+3
  localparam logic [31:0] I_ADD0 = 32'h00220020; // add $0,$1,$2
  localparam logic [31:0] I_DEP  = 32'h00822820; // add $5,$4,$2
  localparam logic [31:0] I_SW4  = 32'hAC240000; // sw $4,0($1)
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  function automatic item_t zero_item();
    item_t it;
    it.e = '0;
    it.chk_sd = 1'b1;
    it.chk_off = 1'b1;
    return it;
  endfunction

  function automatic item_t model_decode(logic [31:0] ins, logic [31:0] rsd, logic [31:0] rtd);
    item_t it;
    logic [31:0] sx;
    it = zero_item();
    sx = {{16{ins[15]}}, ins[15:0]};
    if (ins == 32'h0) return it;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h20 || ins[5:0] == 6'h22) begin
          it.e.valid = 1'b1;
          it.e.ctl = (ins[5:0] == 6'h22) ? 4'b0110 : 4'b0010;
          it.e.a = rsd; it.e.b = rtd; it.e.dest = ins[15:11]; it.e.rw = 1'b1;
        end else begin
          it.e.ill = 1'b1;
        end
      end
      6'h08: begin
        it.e.valid = 1'b1; it.e.ctl = 4'b0010; it.e.a = rsd; it.e.b = sx;
        it.e.dest = ins[20:16]; it.e.rw = 1'b1;
      end
      6'h23: begin
        it.e.valid = 1'b1; it.e.ctl = 4'b0010; it.e.a = rsd; it.e.b = sx;
        it.e.dest = ins[20:16]; it.e.rw = 1'b1; it.e.mr = 1'b1; it.e.m2r = 1'b1;
      end
      6'h2B: begin
        it.e.valid = 1'b1; it.e.ctl = 4'b0010; it.e.a = rsd; it.e.b = sx; it.e.mw = 1'b1;
      end
      6'h04: begin
        it.e.valid = 1'b1; it.e.ctl = 4'b0110; it.e.a = rsd; it.e.b = rtd; it.e.br = 1'b1;
      end
      default: it.e.ill = 1'b1;
    endcase
    if (it.e.valid) begin
      it.e.sd = rtd;
      it.e.off = sx << 2;
      it.chk_sd = (ins[31:26] == 6'h2B);
      it.chk_off = (ins[31:26] == 6'h04);
    end
    if (it.e.dest == 5'd0) it.e.rw = 1'b0;
    return it;
  endfunction

  function automatic logic model_hz(logic v, logic [31:0] ins, ex_t c);
    logic rd_rt;
    rd_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    return v && c.valid && c.mr && (c.dest != 5'd0) &&
           ((c.dest == ins[25:21]) || (c.dest == ins[20:16] && rd_rt));
  endfunction

  // Drives one cycle of inputs, predicts the EX contents and pushes them, then clocks.
  task automatic apply(input logic rst, input logic fl, input logic st, input logic v,
                       input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                       output logic got_hz, output logic exp_hz);
    item_t nxt;
    reset = rst; flush = fl; stall_in = st; id_valid = v;
    id_instr = ins; id_rs_data = rsd; id_rt_data = rtd;
    #1;
    got_hz = hazard_stall;
    exp_hz = model_hz(v, ins, cur.e);
    if (rst) begin
      nxt = zero_item();
      perf_iss_m = 0; perf_bub_m = 0;
    end else if (fl) begin
      nxt = zero_item();
      perf_bub_m = perf_bub_m + 1;
    end else if (st) begin
      nxt = cur;
      nxt.e.ill = 1'b0;
    end else if (exp_hz) begin
      nxt = zero_item();
      perf_bub_m = perf_bub_m + 1;
    end else if (v) begin
      nxt = model_decode(ins, rsd, rtd);
      if (nxt.e.valid) perf_iss_m = perf_iss_m + 1;
    end else begin
      nxt = zero_item();
    end
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    cur = nxt;
  endtask

  task automatic pop(output ex_t got, output ex_t exp, output bit ok);
    item_t it;
    got = '0; exp = '0; ok = 1'b0;
    if (sb.size() == 0) return;
    it = sb.pop_front();
    ok = 1'b1;
    exp = it.e;
    got.valid = ex_valid; got.ctl = ex_alu_control; got.a = ex_alu_a; got.b = ex_alu_b;
    got.sd = ex_store_data; got.off = ex_branch_offset; got.dest = ex_dest_reg;
    got.rw = ex_reg_write; got.mr = ex_mem_read; got.mw = ex_mem_write;
    got.m2r = ex_mem_to_reg; got.br = ex_branch; got.ill = ex_illegal;
    if (!it.chk_sd) begin got.sd = '0; exp.sd = '0; end
    if (!it.chk_off) begin got.off = '0; exp.off = '0; end
  endtask

  task automatic test_reset();
    ex_t g, e; bit ok; logic gh, eh;
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, gh, eh);
      pop(g, e, ok);
      checks++;
      if (!ok || g !== e) begin
        errors++; $display("FAIL reset_state: got=%h exp=%h", g, e);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] prog [7] = '{I_ADD, I_SUB, I_ADDI, I_LW, I_SW, I_BEQ, I_ADD0};
    ex_t g, e; bit ok; logic gh, eh;
    for (int i = 0; i < 7; i++) begin
      apply(0, 0, 0, 1, prog[i], 32'd5 + 32'(i), 32'd7 + 32'(3 * i), gh, eh);
      pop(g, e, ok);
      checks++;
      if (!ok || g !== e || gh !== eh) begin
        errors++; $display("FAIL alu_op[%0d]: got=%h exp=%h hz=%b/%b", i, g, e, gh, eh);
      end
    end
    apply(0, 0, 0, 1, I_ADD, 32'd5, 32'd7, gh, eh);
    checks++;
    if ({ex_valid, ex_alu_control, ex_alu_a, ex_alu_b, ex_dest_reg, ex_reg_write} !==
        {1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b1}) begin
      errors++; $display("FAIL add_literal: got ctl=%b a=%0d b=%0d dest=%0d", ex_alu_control,
                         ex_alu_a, ex_alu_b, ex_dest_reg);
    end
    pop(g, e, ok);
    apply(0, 0, 0, 1, I_BEQ, 32'd1, 32'd2, gh, eh);
    checks++;
    if ({ex_alu_control, ex_branch, ex_reg_write, ex_branch_offset} !==
        {4'b0110, 1'b1, 1'b0, 32'd12}) begin
      errors++; $display("FAIL beq_literal: got ctl=%b br=%b rw=%b off=%0d", ex_alu_control,
                         ex_branch, ex_reg_write, ex_branch_offset);
    end
    pop(g, e, ok);
  endtask

  task automatic test_load_use();
    ex_t g, e; bit ok; logic gh, eh;
    logic [2:0] hz_seen = 3'b000;
    apply(0, 0, 0, 1, I_LW, 32'd100, 32'd0, gh, eh);
    pop(g, e, ok);
    hz_seen[0] = gh;
    apply(0, 0, 0, 1, I_DEP, 32'd9, 32'd2, gh, eh);
    pop(g, e, ok);
    hz_seen[1] = gh;
    checks++;
    if (!ok || g !== e || g.valid !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble: got=%h exp=%h", g, e);
    end
    apply(0, 0, 0, 1, I_DEP, 32'd9, 32'd2, gh, eh);
    pop(g, e, ok);
    hz_seen[2] = gh;
    checks++;
    if (!ok || g !== e || g.dest !== 5'd5) begin
      errors++; $display("FAIL load_use_issue: got=%h exp=%h", g, e);
    end
    checks++;
    if (hz_seen !== 3'b010) begin
      errors++; $display("FAIL load_use_hazard: got=%b exp=010", hz_seen);
    end
  endtask

  task automatic test_illegal();
    ex_t g, e; bit ok; logic gh, eh;
    apply(0, 0, 0, 1, I_ILL, 32'd1, 32'd2, gh, eh);
    pop(g, e, ok);
    checks++;
    if (!ok || g !== e || ex_illegal !== 1'b1 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: got=%h exp=%h", g, e);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 0, 32'h0, 32'h0, 32'h0, gh, eh);
      pop(g, e, ok);
      checks++;
      if (!ok || g !== e || ex_illegal !== 1'b0) begin
        errors++; $display("FAIL illegal_stall[%0d]: got=%h exp=%h", i, g, e);
      end
    end
    apply(0, 0, 0, 1, 32'h0, 32'd1, 32'd2, gh, eh);
    pop(g, e, ok);
    checks++;
    if (!ok || g !== e) begin
      errors++; $display("FAIL nop: got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_stall_flush();
    ex_t g, e, held; bit ok; logic gh, eh;
    apply(0, 0, 0, 1, I_ADD, 32'd11, 32'd22, gh, eh);
    pop(g, e, ok);
    apply(0, 1, 1, 1, I_SUB, 32'd3, 32'd4, gh, eh);
    pop(g, e, ok);
    checks++;
    if (!ok || g !== e || g.valid !== 1'b0) begin
      errors++; $display("FAIL flush_over_stall: got=%h exp=%h", g, e);
    end
    apply(0, 0, 0, 1, I_SUB, 32'd40, 32'd15, gh, eh);
    pop(held, e, ok);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 1, 1, I_ADDI, 32'd77, 32'd88, gh, eh);
      pop(g, e, ok);
      checks++;
      if (!ok || g !== e || g !== held) begin
        errors++; $display("FAIL stall_hold[%0d]: got=%h exp=%h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    ex_t g, e; bit ok; logic gh, eh;
    apply(0, 0, 0, 1, I_ADD, 32'd5, 32'd7, gh, eh);
    pop(g, e, ok);
    apply(0, 0, 1, 1, I_ADD, 32'd5, 32'd7, gh, eh);
    pop(g, e, ok);
    apply(1, 0, 1, 1, I_ADD, 32'd5, 32'd7, gh, eh);
    pop(g, e, ok);
    checks++;
    if (!ok || g !== e || g !== '0) begin
      errors++; $display("FAIL reset_mid_stall: got=%h exp=%h", g, e);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (perf_issued !== 32'd0 || perf_bubbles !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got=%0d/%0d exp=0/0", perf_issued, perf_bubbles);
    end
`endif
    apply(0, 0, 0, 1, I_SUB, 32'd9, 32'd4, gh, eh);
    pop(g, e, ok);
    checks++;
    if (!ok || g !== e || g.valid !== 1'b1) begin
      errors++; $display("FAIL after_reset: got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [10] = '{I_ADD, I_SUB, I_ADDI, I_LW, I_SW, I_BEQ, I_ADD0, I_DEP,
                               I_SW4, I_ILL};
    ex_t g, e; bit ok; logic gh, eh;
    logic [31:0] ins;
    for (int i = 0; i < 200; i++) begin
      ins = ($urandom_range(0, 12) == 0) ? 32'h0 : prog[$urandom_range(0, 9)];
      apply(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0), ins, $urandom,
            $urandom, gh, eh);
      pop(g, e, ok);
      checks++;
      if (!ok || g !== e || gh !== eh) begin
        errors++; $display("FAIL b2b[%0d]: got=%h exp=%h hz=%b/%b", i, g, e, gh, eh);
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (perf_issued !== perf_iss_m || perf_bubbles !== perf_bub_m) begin
        errors++; $display("FAIL b2b_perf[%0d]: got=%0d/%0d exp=%0d/%0d", i, perf_issued,
                           perf_bubbles, perf_iss_m, perf_bub_m);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0; id_valid = 1'b0;
    id_instr = '0; id_rs_data = '0; id_rt_data = '0;
    cur = zero_item();
    @(posedge clk);
    #1;
    test_reset();
    test_alu_ops();
    test_load_use();
    test_illegal();
    test_stall_flush();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
